// File: rtl/forward_unit.sv
// Purpose: operand-forward select and load-use stall generation for a 3-stage-shadow integer pipe.
// Latency: ALUsrc1/ALUsrc2 registered, valid one edge after issue; stall is combinational.
// Backpressure: stall holds fetch/decode for one cycle on a load-use hit; flush overrides everything.
// Optional: define FWD_STALL_CNT_EN to add a saturating 16-bit stall_count output.
module forward_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [2:0]  id_dst,
  input  logic        id_wb,
  input  logic        id_load,
  input  logic        flush,
  output logic [1:0]  ALUsrc1,
  output logic [1:0]  ALUsrc2,
  output logic        stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  // Shadow copy of what sits in execute / memory, enough to decide forwarding.
  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       wb;
    logic       load;
  } shadow_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  shadow_t ex_s;
  shadow_t mem_s;
  state_t  state_q;
  state_t  state_d;

  logic       hit_e1;
  logic       hit_e2;
  logic       hit_m1;
  logic       hit_m2;
  logic       issue;
  logic [1:0] sel1_d;
  logic [1:0] sel2_d;

  // MEMs.load never feeds a hit rule (a load in memory already has its data
  // at the mem forward port); the bit is kept so the shadow mirrors EXs exactly.
  logic unused_mem_load;
  assign unused_mem_load = mem_s.load;

  // Register 0 is an ordinary register here: no zero-index exclusion.
  assign hit_e1 = ex_s.valid  & ex_s.wb  & id_use1 & (id_src1 == ex_s.dst);
  assign hit_e2 = ex_s.valid  & ex_s.wb  & id_use2 & (id_src2 == ex_s.dst);
  assign hit_m1 = mem_s.valid & mem_s.wb & id_use1 & (id_src1 == mem_s.dst);
  assign hit_m2 = mem_s.valid & mem_s.wb & id_use2 & (id_src2 == mem_s.dst);

  assign issue = id_valid & ~stall & ~flush;

  // Newest producer (execute) wins over the older one (memory).
  function automatic logic [1:0] pick_sel(input logic he, input logic hm);
    if (he)      return SEL_ALU;
    else if (hm) return SEL_MEM;
    else         return SEL_REG;
  endfunction

  assign sel1_d = pick_sel(hit_e1, hit_m1);
  assign sel2_d = pick_sel(hit_e2, hit_m2);

  // FSM state register: RUN normally, BUBBLE for the single cycle after a load-use stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a stall edge enters BUBBLE, BUBBLE always returns; flush pins RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (flush)      state_d = RUN;
        else if (stall) state_d = BUBBLE;
      end
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM output: stall on a load in execute feeding the decode instruction, only from RUN.
  always_comb begin
    stall = 1'b0;
    if ((state_q == RUN) && id_valid && !flush && ex_s.load && (hit_e1 || hit_e2))
      stall = 1'b1;
  end

  // Shadow pipe: EXs takes the issuing instruction or a bubble; MEMs always advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s  <= '0;
      mem_s <= '0;
    end else begin
      mem_s <= ex_s;
      if (issue) ex_s <= '{valid: 1'b1, dst: id_dst, wb: id_wb, load: id_load};
      else       ex_s <= '0;
    end
  end

  // Operand selects follow the instruction into execute; bubbles and flushes get register data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUsrc1 <= SEL_REG;
      ALUsrc2 <= SEL_REG;
    end else if (issue) begin
      ALUsrc1 <= sel1_d;
      ALUsrc2 <= sel2_d;
    end else begin
      ALUsrc1 <= SEL_REG;
      ALUsrc2 <= SEL_REG;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of stall cycles; deliberately untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_count <= 16'd0;
    else if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_forward_unit.sv
// Bench for forward_unit: table-driven scenarios, expected selects queued at drive time
// and compared one edge later; stall compared combinationally in the same cycle.
module tb_forward_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_use1;
  logic       id_use2;
  logic [2:0] id_dst;
  logic       id_wb;
  logic       id_load;
  logic       flush;
  logic [1:0] ALUsrc1;
  logic [1:0] ALUsrc2;
  logic       stall;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] sb[$];

  typedef struct packed {
    logic       v;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [2:0] d;
    logic       wb;
    logic       ld;
    logic       fl;
    logic       xs;
    logic [1:0] e1;
    logic [1:0] e2;
  } step_t;

  localparam step_t IDLE = '0;

  forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_dst(id_dst), .id_wb(id_wb), .id_load(id_load), .flush(flush),
    .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2), .stall(stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #60000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic step_t ins(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                                input logic u2, input logic [2:0] d, input logic wb,
                                input logic ld, input logic fl, input logic xs,
                                input logic [1:0] e1, input logic [1:0] e2);
    step_t s;
    s = '{v: 1'b1, s1: s1, u1: u1, s2: s2, u2: u2, d: d, wb: wb, ld: ld, fl: fl,
          xs: xs, e1: e1, e2: e2};
    return s;
  endfunction

  task automatic apply(input step_t s);
    id_valid = s.v;  id_src1 = s.s1; id_use1 = s.u1; id_src2 = s.s2; id_use2 = s.u2;
    id_dst   = s.d;  id_wb   = s.wb; id_load = s.ld; flush   = s.fl;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    rst_n = 1'b0;
    apply(IDLE);
    repeat (2) @(negedge clk);
    got = {ALUsrc1, ALUsrc2};
    total++; if (got !== 4'b0000) begin bad++; $display("FAIL reset_sel got=%b want=0000", got); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
`ifdef FWD_STALL_CNT_EN
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_count); end
`endif
    rst_n = 1'b1;
  endtask

  // REQ: ADD R3 then SUB src1=3 -> 01/00
  task automatic test_ex_fwd;
    step_t st[4];
    logic [3:0] exp;
    st = '{IDLE, IDLE, ins(3'd1,1,3'd2,1,3'd3,1,0,0,0,2'b00,2'b00),
                       ins(3'd3,1,3'd4,1,3'd6,1,0,0,0,2'b01,2'b00)};
    for (int i = 0; i <= $size(st); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front(); total++;
        if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL ex_fwd_sel[%0d] got=%b want=%b", i, {ALUsrc1, ALUsrc2}, exp); end
      end
      if (i < $size(st)) begin
        apply(st[i]); #1; total++;
        if (stall !== st[i].xs) begin bad++; $display("FAIL ex_fwd_stall[%0d] got=%b want=%b", i, stall, st[i].xs); end
        sb.push_back({st[i].e1, st[i].e2});
      end else apply(IDLE);
    end
  endtask

  // ADD R2, NOP, OR src2=2 -> 00/10
  task automatic test_mem_fwd;
    step_t st[5];
    logic [3:0] exp;
    st = '{IDLE, IDLE, ins(3'd0,0,3'd0,0,3'd2,1,0,0,0,2'b00,2'b00), IDLE,
                       ins(3'd7,1,3'd2,1,3'd1,1,0,0,0,2'b00,2'b10)};
    for (int i = 0; i <= $size(st); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front(); total++;
        if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL mem_fwd_sel[%0d] got=%b want=%b", i, {ALUsrc1, ALUsrc2}, exp); end
      end
      if (i < $size(st)) begin
        apply(st[i]); #1; total++;
        if (stall !== st[i].xs) begin bad++; $display("FAIL mem_fwd_stall[%0d] got=%b want=%b", i, stall, st[i].xs); end
        sb.push_back({st[i].e1, st[i].e2});
      end else apply(IDLE);
    end
  endtask

  // ADD R5, AND R5, XOR 5/5 -> 01/01; then use1 off / no-wb producer -> 00/10
  task automatic test_priority;
    step_t st[6];
    logic [3:0] exp;
    st = '{IDLE, IDLE, ins(3'd0,0,3'd0,0,3'd5,1,0,0,0,2'b00,2'b00),
                       ins(3'd0,0,3'd0,0,3'd5,1,0,0,0,2'b00,2'b00),
                       ins(3'd5,1,3'd5,1,3'd0,0,0,0,0,2'b01,2'b01),
                       ins(3'd5,0,3'd5,1,3'd3,0,0,0,0,2'b00,2'b10)};
    for (int i = 0; i <= $size(st); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front(); total++;
        if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL prio_sel[%0d] got=%b want=%b", i, {ALUsrc1, ALUsrc2}, exp); end
      end
      if (i < $size(st)) begin
        apply(st[i]); #1; total++;
        if (stall !== st[i].xs) begin bad++; $display("FAIL prio_stall[%0d] got=%b want=%b", i, stall, st[i].xs); end
        sb.push_back({st[i].e1, st[i].e2});
      end else apply(IDLE);
    end
  endtask

  // LDD R4, ADD src1=4: one stall cycle, bubble 00/00, then ADD gets 10
  task automatic test_load_use;
    step_t st[5];
    logic [3:0] exp;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] c0;
    c0 = stall_count;
`endif
    st = '{IDLE, IDLE, ins(3'd0,0,3'd0,0,3'd4,1,1,0,0,2'b00,2'b00),
                       ins(3'd4,1,3'd0,0,3'd1,1,0,0,1,2'b00,2'b00),
                       ins(3'd4,1,3'd0,0,3'd1,1,0,0,0,2'b10,2'b00)};
    for (int i = 0; i <= $size(st); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front(); total++;
        if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL ldu_sel[%0d] got=%b want=%b", i, {ALUsrc1, ALUsrc2}, exp); end
      end
      if (i < $size(st)) begin
        apply(st[i]); #1; total++;
        if (stall !== st[i].xs) begin bad++; $display("FAIL ldu_stall[%0d] got=%b want=%b", i, stall, st[i].xs); end
        sb.push_back({st[i].e1, st[i].e2});
      end else apply(IDLE);
    end
`ifdef FWD_STALL_CNT_EN
    total++; if (stall_count !== c0 + 16'd1) begin bad++; $display("FAIL ldu_cnt got=%0d want=%0d", stall_count, c0 + 16'd1); end
`endif
  endtask

  // Register 0 forwards like any other; also a load-use on R0 via src2
  task automatic test_reg0;
    step_t st[7];
    logic [3:0] exp;
    st = '{IDLE, IDLE, ins(3'd0,0,3'd0,0,3'd0,1,0,0,0,2'b00,2'b00),
                       ins(3'd0,1,3'd0,1,3'd6,0,0,0,0,2'b01,2'b01),
                       ins(3'd0,0,3'd0,0,3'd0,1,1,0,0,2'b00,2'b00),
                       ins(3'd1,0,3'd0,1,3'd2,1,0,0,1,2'b00,2'b00),
                       ins(3'd1,0,3'd0,1,3'd2,1,0,0,0,2'b00,2'b10)};
    for (int i = 0; i <= $size(st); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front(); total++;
        if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL reg0_sel[%0d] got=%b want=%b", i, {ALUsrc1, ALUsrc2}, exp); end
      end
      if (i < $size(st)) begin
        apply(st[i]); #1; total++;
        if (stall !== st[i].xs) begin bad++; $display("FAIL reg0_stall[%0d] got=%b want=%b", i, stall, st[i].xs); end
        sb.push_back({st[i].e1, st[i].e2});
      end else apply(IDLE);
    end
  endtask

  // Load-use hazard with flush in the same cycle: no stall, 00 selects, MEMs still gets the load
  task automatic test_flush;
    step_t st[5];
    logic [3:0] exp;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] c0;
    c0 = stall_count;
`endif
    st = '{IDLE, IDLE, ins(3'd0,0,3'd0,0,3'd4,1,1,0,0,2'b00,2'b00),
                       ins(3'd4,1,3'd0,0,3'd1,1,0,1,0,2'b00,2'b00),
                       ins(3'd4,1,3'd0,0,3'd1,1,0,0,0,2'b10,2'b00)};
    for (int i = 0; i <= $size(st); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp = sb.pop_front(); total++;
        if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL flush_sel[%0d] got=%b want=%b", i, {ALUsrc1, ALUsrc2}, exp); end
      end
      if (i < $size(st)) begin
        apply(st[i]); #1; total++;
        if (stall !== st[i].xs) begin bad++; $display("FAIL flush_stall[%0d] got=%b want=%b", i, stall, st[i].xs); end
        sb.push_back({st[i].e1, st[i].e2});
      end else apply(IDLE);
    end
`ifdef FWD_STALL_CNT_EN
    total++; if (stall_count !== c0) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", stall_count, c0); end
`endif
  endtask

  // Mid-cycle reset pulse while ADD R1 sits in execute; the follow-up must not forward
  task automatic test_reset_pulse;
    logic [3:0] exp;
    logic [3:0] got;
    @(negedge clk); apply(IDLE);
    @(negedge clk); apply(ins(3'd0,0,3'd0,0,3'd1,1,0,0,0,2'b00,2'b00));
    @(negedge clk); apply(ins(3'd1,1,3'd0,0,3'd1,1,0,0,0,2'b01,2'b00));
    sb.push_back(4'b0100);
    @(negedge clk);
    exp = sb.pop_front(); total++;
    if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL rstp_pre got=%b want=%b", {ALUsrc1, ALUsrc2}, exp); end
    apply(ins(3'd1,1,3'd1,1,3'd2,1,0,0,0,2'b00,2'b00));
    sb.push_back(4'b0000);
    #1 rst_n = 1'b0;
    #1;
    got = {ALUsrc1, ALUsrc2};
    total++; if (got !== 4'b0000) begin bad++; $display("FAIL rstp_async_sel got=%b want=0000", got); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstp_async_stall got=%b want=0", stall); end
    #2 rst_n = 1'b1;
    @(negedge clk);
    exp = sb.pop_front(); total++;
    if ({ALUsrc1, ALUsrc2} !== exp) begin bad++; $display("FAIL rstp_follow got=%b want=%b", {ALUsrc1, ALUsrc2}, exp); end
    apply(IDLE);
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_priority();
    test_load_use();
    test_reg0();
    test_flush();
    test_reset_pulse();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
